tft_bus_responder: RTL and testbench

//  Panel-side end of the 8080-style 8-bit TFT bus (cs/rs/wr/rd/data) driven by the tft block.

---
 rtl/tft_bus_responder_pkg.sv | 35 +++
 rtl/tft_bus_responder_sync.sv | 59 +++++
 rtl/tft_bus_responder.sv | 211 +++++++++++++++++++++
 tb/tb_tft_bus_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_bus_responder_pkg.sv
// Shared definitions for the TFT bus responder: opcodes, decoder states,
// parameter-sequence targets and the window clamp helper.
package tft_bus_responder_pkg;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_RDDID   = 8'h04;
   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PARAM    = 2'd1,
      ST_RAMWR_HI = 2'd2,
      ST_RAMWR_LO = 2'd3
   } dec_state_t;

   // Which register the current parameter sequence is loading
   typedef enum logic [1:0] {
      PT_CASET  = 2'd0,
      PT_PASET  = 2'd1,
      PT_MADCTL = 2'd2
   } param_tgt_t;

   // An inverted window collapses to a single column/row at its start
   function automatic logic [8:0] win_end(input logic [8:0] s, input logic [8:0] e);
      return (e < s) ? s : e;
   endfunction

endpackage

// File: rtl/tft_bus_responder_sync.sv
// tft_bus_sync: brings the asynchronous 8080 bus into the clk domain through
// SYNC_STAGES flops (all lines share one chain so data stays aligned with
// its strobe) and produces single-cycle edge flags for wr, rd and cs.
module tft_bus_sync
   #(parameter int SYNC_STAGES = 2)
   (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       bus_cs_n,
   input  logic       bus_rs,
   input  logic       bus_wr_n,
   input  logic       bus_rd_n,
   input  logic [7:0] bus_data,
   output logic       cs_n_s,
   output logic       rs_s,
   output logic [7:0] data_s,
   output logic       wr_rise,
   output logic       rd_fall,
   output logic       rd_rise,
   output logic       cs_rise
   );

   // {cs_n, rs, wr_n, rd_n, data}; idle bus = deselected, strobes high
   localparam logic [11:0] BUS_IDLE = {1'b1, 1'b0, 1'b1, 1'b1, 8'h00};

   logic [SYNC_STAGES-1:0][11:0] chain;
   logic [11:0] bus_s;
   logic        wr_q, rd_q, cs_q;

   // Shift every bus line through the synchronizer chain
   always_ff @(posedge clk) begin
      if (!reset_n) chain <= {SYNC_STAGES{BUS_IDLE}};
      else          chain <= {chain[SYNC_STAGES-2:0], {bus_cs_n, bus_rs, bus_wr_n, bus_rd_n, bus_data}};
   end

   assign bus_s  = chain[SYNC_STAGES-1];
   assign cs_n_s = bus_s[11];
   assign rs_s   = bus_s[10];
   assign data_s = bus_s[7:0];

   // Previous synced strobe levels for edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q <= 1'b1;
         rd_q <= 1'b1;
         cs_q <= 1'b1;
      end else begin
         wr_q <= bus_s[9];
         rd_q <= bus_s[8];
         cs_q <= bus_s[11];
      end
   end

   assign wr_rise = bus_s[9] & ~wr_q;
   assign rd_fall = ~bus_s[8] & rd_q;
   assign rd_rise = bus_s[8] & ~rd_q;
   assign cs_rise = bus_s[11] & ~cs_q;

endmodule

// File: rtl/tft_bus_responder.sv
// tft_bus_responder: panel-side decoder for the 8-bit 8080 TFT bus.
// Decodes CASET/PASET/MADCTL/RAMWR/SLPIN/SLPOUT/DISPON/DISPOFF/SWRESET and
// emits addressed RGB565 pixel writes. Define TFT_RESPONDER_READ_EN to add
// RDDID readback on rd_data/rd_oe; otherwise those outputs are tied low.
module tft_bus_responder
   import tft_bus_responder_pkg::*;
   #(
   parameter int          SYNC_STAGES = 2,
   parameter int          COLS        = 240,
   parameter int          ROWS        = 320,
   parameter logic [23:0] PANEL_ID    = 24'h009341
   )
   (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bus_cs_n,
   input  logic        bus_rs,
   input  logic        bus_wr_n,
   input  logic        bus_rd_n,
   input  logic [7:0]  bus_data,
   output logic [7:0]  rd_data,
   output logic        rd_oe,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        px_valid,
   output logic [8:0]  px_x,
   output logic [8:0]  px_y,
   output logic [15:0] px_data,
   output logic        display_on,
   output logic        sleep_out,
   output logic [7:0]  madctl
   );

   localparam logic [8:0] EC_RST = 9'(COLS - 1);
   localparam logic [8:0] EP_RST = 9'(ROWS - 1);

   logic       cs_n_s, rs_s, wr_rise, rd_fall, rd_rise, cs_rise;
   logic [7:0] data_s;
   logic       strobe, cmd_byte, soft_rst;

   tft_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus_cs_n (bus_cs_n),
      .bus_rs   (bus_rs),
      .bus_wr_n (bus_wr_n),
      .bus_rd_n (bus_rd_n),
      .bus_data (bus_data),
      .cs_n_s   (cs_n_s),
      .rs_s     (rs_s),
      .data_s   (data_s),
      .wr_rise  (wr_rise),
      .rd_fall  (rd_fall),
      .rd_rise  (rd_rise),
      .cs_rise  (cs_rise)
   );

   assign strobe   = wr_rise & ~cs_n_s;
   assign cmd_byte = strobe & ~rs_s;
   assign soft_rst = cmd_byte & (data_s == CMD_SWRESET);

   dec_state_t state;
   param_tgt_t ptgt;
   logic [1:0] pidx;
   logic       p_shi, p_ehi;
   logic [7:0] p_slo, hi_byte;
   logic [8:0] sc, ec, sp, ep, x, y;
   logic [8:0] new_s, new_e;

   // Window candidate formed when the 4th CASET/PASET byte arrives
   assign new_s = {p_shi, p_slo};
   assign new_e = win_end(new_s, {p_ehi, data_s});

   // Command code is kept across SWRESET, so it lives apart from the decoder
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd_valid <= 1'b0;
         cmd_code  <= 8'h00;
      end else begin
         cmd_valid <= cmd_byte;
         if (cmd_byte) cmd_code <= data_s;
      end
   end

   // Decoder FSM, window registers and pixel address counters
   always_ff @(posedge clk) begin
      if (!reset_n || soft_rst) begin
         state      <= ST_IDLE;
         ptgt       <= PT_CASET;
         pidx       <= 2'd0;
         p_shi      <= 1'b0;
         p_ehi      <= 1'b0;
         p_slo      <= 8'h00;
         hi_byte    <= 8'h00;
         sc         <= 9'd0;
         ec         <= EC_RST;
         sp         <= 9'd0;
         ep         <= EP_RST;
         x          <= 9'd0;
         y          <= 9'd0;
         px_valid   <= 1'b0;
         px_x       <= 9'd0;
         px_y       <= 9'd0;
         px_data    <= 16'h0000;
         display_on <= 1'b0;
         sleep_out  <= 1'b0;
         madctl     <= 8'h00;
      end else begin
         px_valid <= 1'b0;
         if (strobe && !rs_s) begin
            // Any command aborts the running sequence, dropping a half pixel
            state <= ST_IDLE;
            case (data_s)
               CMD_CASET:   begin state <= ST_PARAM; ptgt <= PT_CASET;  pidx <= 2'd0; end
               CMD_PASET:   begin state <= ST_PARAM; ptgt <= PT_PASET;  pidx <= 2'd0; end
               CMD_MADCTL:  begin state <= ST_PARAM; ptgt <= PT_MADCTL; pidx <= 2'd0; end
               CMD_RAMWR:   begin state <= ST_RAMWR_HI; x <= sc; y <= sp; end
               CMD_SLPOUT:  sleep_out  <= 1'b1;
               CMD_SLPIN:   sleep_out  <= 1'b0;
               CMD_DISPON:  display_on <= 1'b1;
               CMD_DISPOFF: display_on <= 1'b0;
               default: ;
            endcase
         end else if (strobe) begin
            case (state)
               ST_PARAM: begin
                  if (ptgt == PT_MADCTL) begin
                     madctl <= data_s;
                     state  <= ST_IDLE;
                  end else begin
                     pidx <= pidx + 2'd1;
                     case (pidx)
                        2'd0: p_shi <= data_s[0];
                        2'd1: p_slo <= data_s;
                        2'd2: p_ehi <= data_s[0];
                        default: begin
                           state <= ST_IDLE;
                           if (ptgt == PT_CASET) begin sc <= new_s; ec <= new_e; end
                           else                  begin sp <= new_s; ep <= new_e; end
                        end
                     endcase
                  end
               end
               ST_RAMWR_HI: begin
                  hi_byte <= data_s;
                  state   <= ST_RAMWR_LO;
               end
               ST_RAMWR_LO: begin
                  px_valid <= 1'b1;
                  px_data  <= {hi_byte, data_s};
                  px_x     <= x;
                  px_y     <= y;
                  state    <= ST_RAMWR_HI;
                  if (x == ec) begin
                     x <= sc;
                     y <= (y == ep) ? sp : y + 9'd1;
                  end else begin
                     x <= x + 9'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TFT_RESPONDER_READ_EN
   logic       rd_armed;
   logic [2:0] rd_idx;
   logic [7:0] id_byte;

   // Readback sequence: dummy byte, three ID bytes, then zeros
   always_comb begin
      id_byte = 8'h00;
      case (rd_idx)
         3'd1: id_byte = PANEL_ID[23:16];
         3'd2: id_byte = PANEL_ID[15:8];
         3'd3: id_byte = PANEL_ID[7:0];
         default: id_byte = 8'h00;
      endcase
   end

   // RDDID arms readback; every other command disarms it
   always_ff @(posedge clk) begin
      if (!reset_n || soft_rst) begin
         rd_armed <= 1'b0;
         rd_idx   <= 3'd0;
         rd_oe    <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         if (cmd_byte) begin
            rd_armed <= (data_s == CMD_RDDID);
            rd_idx   <= 3'd0;
         end
         if (rd_rise || cs_rise) begin
            rd_oe <= 1'b0;
         end else if (rd_fall && !cs_n_s && rd_armed) begin
            rd_oe   <= 1'b1;
            rd_data <= id_byte;
            if (rd_idx != 3'd4) rd_idx <= rd_idx + 3'd1;
         end
      end
   end
`else
   logic unused_rd;
   assign unused_rd = &{1'b0, rd_fall, rd_rise, cs_rise, PANEL_ID};
   assign rd_oe     = 1'b0;
   assign rd_data   = 8'h00;
`endif

endmodule

// File: tb/tb_tft_bus_responder.sv
// Bench for tft_bus_responder: directed bus transfers, a byte-level model of
// the command set that predicts every cmd/pixel pulse and its cycle, a
// per-cycle monitor, and literal expectations for the documented scenarios.
module tb_tft_bus_responder;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        bus_cs_n = 1'b1, bus_rs = 1'b0, bus_wr_n = 1'b1, bus_rd_n = 1'b1;
   logic [7:0]  bus_data = 8'h00;
   logic [7:0]  rd_data, cmd_code, madctl;
   logic        rd_oe, cmd_valid, px_valid, display_on, sleep_out;
   logic [8:0]  px_x, px_y;
   logic [15:0] px_data;

   tft_bus_responder #(.SYNC_STAGES(SYNC), .COLS(240), .ROWS(320), .PANEL_ID(24'h009341)) dut (
      .clk(clk), .reset_n(reset_n), .bus_cs_n(bus_cs_n), .bus_rs(bus_rs), .bus_wr_n(bus_wr_n),
      .bus_rd_n(bus_rd_n), .bus_data(bus_data), .rd_data(rd_data), .rd_oe(rd_oe),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
      .px_data(px_data), .display_on(display_on), .sleep_out(sleep_out), .madctl(madctl)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int due; int code; } cmd_exp_t;
   typedef struct { int due; int x; int y; int d; } px_exp_t;
   cmd_exp_t cmd_q[$];
   px_exp_t  px_q[$];

   // mode: 0 idle/ignore, 1 CASET, 2 PASET, 3 MADCTL, 4 RAMWR
   int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_np, m_hi, m_madctl, m_cmd;
   int m_p[4];
   bit m_have_hi, m_disp, m_sleep;

   task automatic model_soft();
      m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319; m_x = 0; m_y = 0;
      m_mode = 0; m_np = 0; m_have_hi = 0; m_disp = 0; m_sleep = 0; m_madctl = 0;
   endtask

   task automatic model_reset();
      model_soft();
      m_cmd = 0;
      cmd_q.delete();
      px_q.delete();
   endtask

   task automatic model_byte(input logic rs, input logic [7:0] d, input int due);
      int s, e;
      if (!rs) begin
         cmd_q.push_back('{due, int'(d)});
         m_cmd = d; m_mode = 0; m_np = 0; m_have_hi = 0;
         case (d)
            8'h01: model_soft();
            8'h2A: m_mode = 1;
            8'h2B: m_mode = 2;
            8'h36: m_mode = 3;
            8'h2C: begin m_mode = 4; m_x = m_sc; m_y = m_sp; end
            8'h11: m_sleep = 1;
            8'h10: m_sleep = 0;
            8'h29: m_disp = 1;
            8'h28: m_disp = 0;
            default: ;
         endcase
      end else begin
         if (m_mode == 3) begin
            m_madctl = d; m_mode = 0;
         end else if (m_mode == 1 || m_mode == 2) begin
            m_p[m_np] = d; m_np++;
            if (m_np == 4) begin
               s = (m_p[0] % 2) * 256 + m_p[1];
               e = (m_p[2] % 2) * 256 + m_p[3];
               if (e < s) e = s;
               if (m_mode == 1) begin m_sc = s; m_ec = e; end
               else             begin m_sp = s; m_ep = e; end
               m_mode = 0;
            end
         end else if (m_mode == 4) begin
            if (!m_have_hi) begin
               m_hi = d; m_have_hi = 1;
            end else begin
               px_q.push_back('{due, m_x, m_y, m_hi * 256 + int'(d)});
               m_have_hi = 0;
               if (m_x == m_ec) begin
                  m_x = m_sc;
                  m_y = (m_y == m_ep) ? m_sp : m_y + 1;
               end else m_x++;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------
   int seen_x[$], seen_y[$], seen_d[$];
   int n_cmd_seen = 0, last_px_cyc = 0, last_rise = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL cmd_unexpected: got code %0h expected no pulse (cycle %0d)", cmd_code, cyc);
            end else begin
               cmd_exp_t ce;
               ce = cmd_q.pop_front();
               chk("cmd_code", cmd_code, ce.code);
               chk("cmd_latency", cyc, ce.due);
            end
            n_cmd_seen++;
         end else if (cmd_q.size() > 0 && cyc > cmd_q[0].due) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_missing: got no pulse expected code %0h", cmd_q[0].code);
            void'(cmd_q.pop_front());
         end
         if (px_valid) begin
            seen_x.push_back(px_x); seen_y.push_back(px_y); seen_d.push_back(px_data);
            last_px_cyc = cyc;
            if (px_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL px_unexpected: got (%0d,%0d) %0h expected no pulse", px_x, px_y, px_data);
            end else begin
               px_exp_t pe;
               pe = px_q.pop_front();
               chk("px_x", px_x, pe.x);
               chk("px_y", px_y, pe.y);
               chk("px_data", px_data, pe.d);
               chk("px_latency", cyc, pe.due);
            end
         end else if (px_q.size() > 0 && cyc > px_q[0].due) begin
            n_checks++; n_fail++;
            $display("FAIL px_missing: got no pulse expected (%0d,%0d)", px_q[0].x, px_q[0].y);
            void'(px_q.pop_front());
         end
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic rs, input logic [7:0] d, input bit cs_active);
      @(negedge clk);
      bus_cs_n = !cs_active; bus_rs = rs; bus_data = d; bus_wr_n = 1'b0;
      repeat (3) @(negedge clk);
      bus_wr_n = 1'b1;
      last_rise = cyc;
      if (cs_active) model_byte(rs, d, cyc + SYNC + 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic cmd(input logic [7:0] d);
      bus_write(1'b0, d, 1'b1);
   endtask

   task automatic dat(input logic [7:0] d);
      bus_write(1'b1, d, 1'b1);
   endtask

   task automatic cs_idle(input int n);
      @(negedge clk);
      bus_cs_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_seen();
      seen_x.delete(); seen_y.delete(); seen_d.delete();
   endtask

   task automatic check_static(input string tag);
      chk({tag, "_display_on"}, display_on, m_disp);
      chk({tag, "_sleep_out"}, sleep_out, m_sleep);
      chk({tag, "_madctl"}, madctl, m_madctl);
      chk({tag, "_cmd_code"}, cmd_code, m_cmd);
   endtask

   task automatic check_seen(input string tag, input int n, input int xs[8], input int ys[8]);
      chk({tag, "_count"}, seen_x.size(), n);
      for (int i = 0; i < n && i < seen_x.size(); i++) begin
         chk({tag, "_x"}, seen_x[i], xs[i]);
         chk({tag, "_y"}, seen_y[i], ys[i]);
      end
   endtask

`ifdef TFT_RESPONDER_READ_EN
   task automatic bus_read(output logic [7:0] d, output logic oe_low, output logic oe_high);
      @(negedge clk);
      bus_rd_n = 1'b0;
      repeat (4) @(negedge clk);
      d = rd_data; oe_low = rd_oe;
      bus_rd_n = 1'b1;
      repeat (4) @(negedge clk);
      oe_high = rd_oe;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int cnt0;
      model_reset();
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // reset state
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_px_valid", px_valid, 0);
      chk("rst_px_x", px_x, 0);
      chk("rst_px_y", px_y, 0);
      chk("rst_px_data", px_data, 0);
      chk("rst_cmd_code", cmd_code, 0);
      chk("rst_display_on", display_on, 0);
      chk("rst_sleep_out", sleep_out, 0);
      chk("rst_madctl", madctl, 0);
      chk("rst_rd_oe", rd_oe, 0);
      chk("rst_rd_data", rd_data, 0);

      // first pixel after reset lands at (0,0) with SYNC+1 latency
      clear_seen();
      cmd(8'h2C); dat(8'hF8); dat(8'h00);
      chk("t2_count", seen_x.size(), 1);
      chk("t2_latency", last_px_cyc - last_rise, SYNC + 1);
      if (seen_x.size() > 0) begin
         chk("t2_x", seen_x[0], 0);
         chk("t2_y", seen_y[0], 0);
         chk("t2_data", seen_d[0], 16'hF800);
      end

      // 3x2 window raster
      clear_seen();
      cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
      cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
      cmd(8'h2C);
      for (int i = 0; i < 6; i++) begin dat(8'(8'h10 + i)); dat(8'(8'hA0 + i)); end
      check_seen("t1", 6, '{10, 11, 12, 10, 11, 12, 0, 0}, '{5, 5, 5, 6, 6, 6, 0, 0});
      if (seen_d.size() > 5) chk("t1_data5", seen_d[5], 16'h15A5);

      // half pixel dropped by a following command
      clear_seen();
      cnt0 = n_cmd_seen;
      cmd(8'h2C); dat(8'hAB);
      cmd(8'h29);
      chk("t3_px_count", seen_x.size(), 0);
      chk("t3_display_on", display_on, 1);
      chk("t3_cmd_count", n_cmd_seen - cnt0, 2);

      // single-cell window at the far corner
      clear_seen();
      cmd(8'h2A); dat(8'h00); dat(8'hEF); dat(8'h00); dat(8'hEF);
      cmd(8'h2B); dat(8'h01); dat(8'h3F); dat(8'h01); dat(8'h3F);
      cmd(8'h2C); dat(8'h12); dat(8'h34); dat(8'h56); dat(8'h78);
      check_seen("t4", 2, '{239, 239, 0, 0, 0, 0, 0, 0}, '{319, 319, 0, 0, 0, 0, 0, 0});

      // inverted column window collapses to its start; partial pixel survives cs high
      clear_seen();
      cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h05);
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2C); dat(8'h11); cs_idle(6); dat(8'h22); dat(8'h33); dat(8'h44);
      check_seen("tinv", 2, '{10, 10, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});
      if (seen_d.size() > 0) chk("tinv_data0", seen_d[0], 16'h1122);

      // unknown opcode swallows its data bytes
      clear_seen();
      cmd(8'h55); dat(8'h01); dat(8'h02);
      chk("tunk_px_count", seen_x.size(), 0);

      // MADCTL, sleep flag and SWRESET
      cmd(8'h36); dat(8'h48);
      cmd(8'h11);
      chk("tflag_madctl", madctl, 8'h48);
      chk("tflag_sleep", sleep_out, 1);
      check_static("tflag");
      cmd(8'h01);
      chk("tsw_madctl", madctl, 0);
      chk("tsw_display", display_on, 0);
      chk("tsw_cmd_code", cmd_code, 8'h01);
      check_static("tsw");

      // strobes with cs high are ignored, then reset mid-CASET
      cmd(8'h29);
      cnt0 = n_cmd_seen;
      cs_idle(4);
      bus_write(1'b0, 8'h28, 1'b0);
      bus_write(1'b0, 8'h2C, 1'b0);
      chk("t5_cs_cmd_count", n_cmd_seen - cnt0, 0);
      chk("t5_cs_display", display_on, 1);
      cmd(8'h2A); dat(8'h00); dat(8'h05);
      do_reset();
      chk("t5_rst_display", display_on, 0);
      chk("t5_rst_cmd_code", cmd_code, 0);
      chk("t5_rst_px_x", px_x, 0);
      chk("t5_rst_px_data", px_data, 0);
      clear_seen();
      dat(8'h00); dat(8'hEE);
      chk("t5_stale_px", seen_x.size(), 0);
      cmd(8'h2C);
      for (int i = 0; i < 241; i++) begin dat(8'h00); dat(8'(i)); end
      chk("t5_count", seen_x.size(), 241);
      if (seen_x.size() == 241) begin
         chk("t5_x0", seen_x[0], 0);
         chk("t5_x239", seen_x[239], 239);
         chk("t5_y239", seen_y[239], 0);
         chk("t5_x240", seen_x[240], 0);
         chk("t5_y240", seen_y[240], 1);
      end

`ifdef TFT_RESPONDER_READ_EN
      begin
         logic [7:0] rb, exp_rb[5];
         logic oe_l, oe_h;
         exp_rb = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};
         cmd(8'h04);
         for (int i = 0; i < 5; i++) begin
            bus_read(rb, oe_l, oe_h);
            chk("t6_rd_data", rb, exp_rb[i]);
            chk("t6_oe_low", oe_l, 1);
            chk("t6_oe_high", oe_h, 0);
         end
         cmd(8'h29);
         bus_read(rb, oe_l, oe_h);
         chk("t6_disarmed_oe", oe_l, 0);
      end
`else
      begin
         cmd(8'h04); dat(8'h01);
         repeat (3) begin
            @(negedge clk); bus_rd_n = 1'b0;
            repeat (4) @(negedge clk);
            chk("t6_rd_oe_tied", rd_oe, 0);
            chk("t6_rd_data_tied", rd_data, 0);
            bus_rd_n = 1'b1;
            repeat (4) @(negedge clk);
         end
      end
`endif

      check_static("final");
      repeat (10) @(negedge clk);
      chk("final_cmd_q_empty", cmd_q.size(), 0);
      chk("final_px_q_empty", px_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
